// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
// Contents: requester count, index and hold-counter widths, the FSM
// state type, and a modulo-N_REQ increment used to rotate the pointer.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Next requester index after i, wrapping N_REQ-1 back to 0.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return IDX_W'((32'(i) + 1) % N_REQ);
    endfunction

endpackage

// File: rtl/rr_arbiter_idx4_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// Signals:
//   req          request lines, bit i = requester i
//   done         current owner finished (meaningful only while gnt_valid=1)
//   gnt_valid    grant active
//   gnt_idx      index of the granted requester
//   timeout_flag one-cycle pulse when a grant is revoked by the hold timeout
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter_idx4_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic             timeout_flag;

    modport master (
        output req,
        output done,
        input  gnt_valid,
        input  gnt_idx,
        input  timeout_flag
    );

    modport slave (
        input  req,
        input  done,
        output gnt_valid,
        output gnt_idx,
        output timeout_flag
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker.
// Ports:
//   req [3:0]  live request vector
//   ptr [1:0]  highest-priority index for this pick
//   any        at least one request is set
//   idx [1:0]  first set request searching ptr, ptr+1, ... modulo 4
// The request vector is rotated so that ptr lands on bit 0, a fixed
// priority find picks the lowest set bit, and the offset is added back.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;
    logic             found;

    always_comb begin
        rot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // 2-bit index arithmetic wraps modulo 4 by itself
            rot[k] = req[IDX_W'(k) + ptr];
        end
    end

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (rot[k] && !found) begin
                off   = IDX_W'(k);
                found = 1'b1;
            end
        end
    end

    assign any = |req;
    assign idx = off + ptr;

endmodule

// File: rtl/rr_arbiter_idx4.sv
// Four-requester round-robin arbiter with registered index/valid outputs.
// Parameters:
//   TIMEOUT  maximum grant length in cycles (0 = unbounded), 0..255
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   bus      slave side of rr_arbiter_idx4_if (req/done in, grant out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; arbitrate the live req vector from ptr each cycle
// GRANT | gnt_idx owns the resource until done, withdrawal or timeout
//
// Every grant is followed by at least one IDLE cycle, so the index never
// changes while gnt_valid is high. All outputs are flop outputs.
module rr_arbiter_idx4
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic               clk,
    input  logic               rst,
    rr_arbiter_idx4_if.slave   bus
);

    arb_state_t       state_q, state_nxt;
    logic [IDX_W-1:0] ptr_q, ptr_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic             valid_q, valid_nxt;
    logic             flag_q, flag_nxt;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_done;
    logic             owner_gone;
    logic             hold_expired;

    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign owner_done = bus.done;
    assign owner_gone = ~bus.req[idx_q];

    // Hold counter: cleared while idle, so it reads 0 on the first grant
    // cycle; saturates instead of wrapping. Absent when TIMEOUT=0.
    if (TIMEOUT != 0) begin : g_timer
        logic [CNT_W-1:0] cnt_q, cnt_nxt;

        always_comb begin
            cnt_nxt = cnt_q;
            if (state_q == IDLE) begin
                cnt_nxt = '0;
            end else if (cnt_q != '1) begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_nxt;
            end
        end

        assign hold_expired = (state_q == GRANT) && (cnt_q == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_timer
        assign hold_expired = 1'b0;
    end

    always_comb begin
        state_nxt = state_q;
        ptr_nxt   = ptr_q;
        idx_nxt   = idx_q;
        valid_nxt = valid_q;
        flag_nxt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = GRANT;
                    valid_nxt = 1'b1;
                    idx_nxt   = pick_idx;
                end
            end
            GRANT: begin
                if (owner_done || owner_gone || hold_expired) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    ptr_nxt   = idx_inc(idx_q);
                    // flag only when the timer alone ended the grant
                    flag_nxt  = hold_expired && !owner_done && !owner_gone;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ptr_q   <= ptr_nxt;
            idx_q   <= idx_nxt;
            valid_q <= valid_nxt;
            flag_q  <= flag_nxt;
        end
    end

    assign bus.gnt_valid    = valid_q;
    assign bus.gnt_idx      = idx_q;
    assign bus.timeout_flag = flag_q;

endmodule

// File: tb/tb_rr_arbiter_idx4.sv
module tb_rr_arbiter_idx4;
    import arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_v = 4'b0000;
    logic       done_v = 1'b0;

    always #5 clk = ~clk;

    rr_arbiter_idx4_if bus4 ();
    rr_arbiter_idx4_if bus0 ();

    assign bus4.req  = req_v;
    assign bus4.done = done_v;
    assign bus0.req  = req_v;
    assign bus0.done = done_v;

    rr_arbiter_idx4 #(.TIMEOUT(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    rr_arbiter_idx4 #(.TIMEOUT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    int errors = 0;
    int checks = 0;

    // Reference model, one slot per DUT: [0] TIMEOUT=4, [1] TIMEOUT=0.
    int tmo [2] = '{4, 0};
    bit mv  [2];   // grant active
    int mi  [2];   // granted index (held while idle)
    int mp  [2];   // next search start
    int mh  [2];   // cycles the current grant has been visible
    bit mf  [2];   // timeout pulse

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mv[i] = 1'b0;
            mi[i] = 0;
            mp[i] = 0;
            mh[i] = 0;
            mf[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit found;
        int c;
        bit wd;
        bit to;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (!mv[i]) begin
                mf[i] = 1'b0;
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    c = (mp[i] + k) % 4;
                    if (!found && req_v[c]) begin
                        mi[i] = c;
                        found = 1'b1;
                    end
                end
                if (found) begin
                    mv[i] = 1'b1;
                    mh[i] = 1;
                end
            end else begin
                wd = !req_v[mi[i]];
                to = (tmo[i] != 0) && (mh[i] == tmo[i]);
                if (done_v || wd || to) begin
                    mv[i] = 1'b0;
                    mp[i] = (mi[i] + 1) % 4;
                    mf[i] = to && !done_v && !wd;
                end else begin
                    mh[i] = mh[i] + 1;
                    mf[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        chk({step, " t4.valid"}, {7'd0, bus4.gnt_valid},    {7'd0, mv[0]});
        chk({step, " t4.idx"},   {6'd0, bus4.gnt_idx},      8'(mi[0]));
        chk({step, " t4.flag"},  {7'd0, bus4.timeout_flag}, {7'd0, mf[0]});
        chk({step, " t0.valid"}, {7'd0, bus0.gnt_valid},    {7'd0, mv[1]});
        chk({step, " t0.idx"},   {6'd0, bus0.gnt_idx},      8'(mi[1]));
        chk({step, " t0.flag"},  {7'd0, bus0.timeout_flag}, {7'd0, mf[1]});
    endtask

    task automatic tick(input string step);
        @(posedge clk);
        model_edge();
        #1;
        check_all(step);
    endtask

    initial begin
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // reset in the middle of a grant to idx 2
        req_v = 4'b0100;
        tick("mid grant");
        tick("mid hold");
        chk("mid idx2", {6'd0, bus4.gnt_idx}, 8'd2);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async rst");
        chk("async valid", {7'd0, bus4.gnt_valid}, 8'd0);
        #1;
        rst = 1'b0;
        req_v = 4'b1000;
        tick("post rst grant");
        chk("post rst idx3", {6'd0, bus4.gnt_idx}, 8'd3);
        req_v = 4'b0000;
        tick("post rst rel");
        tick("post rst idle");

        // rotation with all requesting, done every grant cycle
        req_v  = 4'b1111;
        done_v = 1'b1;
        repeat (10) tick("rotate");
        req_v  = 4'b0000;
        done_v = 1'b0;
        tick("rotate idle");

        // wrap from ptr=3
        req_v = 4'b0100;
        tick("wrap g2");
        done_v = 1'b1;
        tick("wrap rel2");
        done_v = 1'b0;
        req_v  = 4'b0011;
        tick("wrap g0");
        chk("wrap idx0", {6'd0, bus4.gnt_idx}, 8'd0);
        done_v = 1'b1;
        tick("wrap rel0");
        done_v = 1'b0;
        tick("wrap g1");
        chk("wrap idx1", {6'd0, bus4.gnt_idx}, 8'd1);

        // withdrawal of the owner
        req_v = 4'b0001;
        tick("withdraw");
        req_v = 4'b1111;
        tick("withdraw next");
        chk("withdraw ptr2", {6'd0, bus4.gnt_idx}, 8'd2);
        done_v = 1'b1;
        tick("withdraw rel");
        done_v = 1'b0;
        req_v  = 4'b0000;
        tick("withdraw idle");

        // timeout with a single persistent requester
        req_v = 4'b0001;
        repeat (14) tick("timeout");
        req_v = 4'b0000;
        repeat (2) tick("timeout idle");

        // done coincident with timeout
        req_v = 4'b0001;
        tick("sim grant");
        repeat (3) tick("sim hold");
        done_v = 1'b1;
        tick("sim done+to");
        chk("sim noflag", {7'd0, bus4.timeout_flag}, 8'd0);
        done_v = 1'b0;
        req_v  = 4'b0000;
        repeat (2) tick("sim idle");

        // withdrawal coincident with timeout
        req_v = 4'b0001;
        tick("wto grant");
        repeat (3) tick("wto hold");
        req_v = 4'b0000;
        tick("wto drop+to");
        chk("wto noflag", {7'd0, bus4.timeout_flag}, 8'd0);
        tick("wto idle");

        // long hold: TIMEOUT=0 never revokes
        req_v = 4'b0001;
        repeat (300) tick("long hold");
        chk("long t0 valid", {7'd0, bus0.gnt_valid}, 8'd1);
        req_v = 4'b0000;
        repeat (2) tick("long idle");

        // randomized traffic
        repeat (400) begin
            if ($urandom_range(0, 7) == 0) req_v = 4'($urandom_range(0, 15));
            done_v = ($urandom_range(0, 5) == 0);
            tick("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
